md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit with HI/LO registers, placed in the execute stage beside the ALU of the five-stage pipeline. It accepts one operation per start pulse, models a fixed multi-cycle latency with a busy counter, and commits the 2×WIDTH result to HI/LO on completion. The stall controller uses its `Busy`/`Start` outputs to hold HI/LO readers and further multiply/divide operations in decode.

## Interface
- `WIDTH`, 32, operand and HI/LO width.
- `MULT_CYCLES`, 5, busy cycles for mult/multu (and madd/maddu); must be ≥1.
- `DIV_CYCLES`, 10, busy cycles for div/divu; must be ≥1.

- `Clk`  in  1  clock, rising-edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  operation request, sampled on the rising edge.
- `MDOp`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
- `A`  in  WIDTH  rs operand (E-stage forwarded).
- `B`  in  WIDTH  rt operand (E-stage forwarded).
- `Busy`  out  1  operation in flight.
- `Done`  out  1  one-cycle pulse; HI/LO now hold the new result.
- `HI`  out  WIDTH  HI register (mfhi source).
- `LO`  out  WIDTH  LO register (mflo source).

## Operation
- Reset: `HI`=0, `LO`=0, `Busy`=0, `Done`=0, counter=0, pending result cleared; takes effect immediately, aborting any operation in flight.
- States: IDLE (counter=0) and RUN (counter>0).
- IDLE, `Start`=1:
  - mthi/mtlo: `HI`/`LO`←`A` at that edge; no busy, no `Done`.
  - mult/multu: pending {HI,LO}←A×B (signed/unsigned, full 2×WIDTH product); counter←MULT_CYCLES.
  - div/divu: pending LO←quotient, HI←remainder (signed: truncate toward zero, remainder takes the dividend's sign); counter←DIV_CYCLES.
  - madd/maddu: see Configuration.
- RUN: counter decrements each edge. On the edge where it goes 1→0, pending is committed to HI/LO and `Done` is set for one cycle.
- `Start` while `Busy`=1 is ignored with no state change, including mthi/mtlo. The stall controller guarantees this never happens.
- Divide by zero: LO←all ones, HI←A.
- Signed overflow (A=−2^(WIDTH−1), B=−1): LO←A, HI←0.
- Opcodes 6/7 without the macro: ignored.
- Operands are captured at the start edge; later changes on A/B have no effect.

## Timing
- `Start` sampled at edge t.
- `Busy`=1 from t+ through edge t+N, where N = MULT_CYCLES or DIV_CYCLES.
- At edge t+N: HI/LO updated, `Busy`→0, `Done`=1 for that one cycle.
- Back-to-back: a new `Start` is accepted at edge t+N+1 at the earliest; the `Start` in the `Done` cycle is accepted.
- mthi/mtlo: HI/LO visible the cycle after the start edge.
- Stall contract: decode stalls any md/mfhi/mflo instruction while `Busy`=1 or (`Start`=1 in E).
- `HI`/`LO` are register outputs; no combinational path exists from inputs to outputs.

## Configuration
- `MDU_MADD_EN` defined:
  - MDOp 6/7 perform {HI,LO} ← {HI,LO} + A×B (signed/unsigned product, mod 2^(2·WIDTH)).
  - The accumulator base is the HI/LO value at the start edge; latency is MULT_CYCLES.
- `MDU_MADD_EN` undefined:
  - MDOp 6/7 are ignored (no busy, no state change).
  - No accumulate adder is synthesised.

## Structure
- Shared package `mdu_pkg`: MDOp encoding constants (`MD_MULT` … `MD_MADDU`) and the 3-bit op typedef. `ctrl_E` and the stall unit import the same constants.
- Sub-module `md_calc`: purely combinational. Inputs are A, B, op, current HI/LO. Outputs are the pending {HI,LO} value, including the divide-by-zero, overflow and madd cases.
- `md_unit` holds the counter, pending register, HI/LO and `Done`.

## Test plan
- mult: A=0xFFFFFFFE, B=3 signed → after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, `Done` one cycle. multu with the same operands → HI=0x2, LO=0xFFFFFFFA.
- div: A=−7, B=2 → `Busy` 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 → LO=0xFFFFFFFF, HI=7. div 0x80000000/−1 → LO=0x80000000, HI=0.
- mthi A=0x1234 then mtlo A=0x5678 on consecutive cycles → HI=0x1234, LO=0x5678 the next cycles, `Busy` never high.
- `Start` div during mult RUN → ignored: the mult result is committed at cycle 5 and `Busy` drops as scheduled.
- `Reset` low at busy cycle 3 of a div → HI=LO=0 and `Busy`=0 immediately, no `Done`. A fresh mult after reset completes normally.
- With `MDU_MADD_EN`, HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0. Without the macro, the same op leaves HI/LO unchanged and `Busy`=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared multiply/divide opcode encoding and MDU state type.
// The decode controller and the stall unit import the same constants.
package mdu_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MULT  = 3'd0;
  localparam md_op_t MD_MULTU = 3'd1;
  localparam md_op_t MD_DIV   = 3'd2;
  localparam md_op_t MD_DIVU  = 3'd3;
  localparam md_op_t MD_MTHI  = 3'd4;
  localparam md_op_t MD_MTLO  = 3'd5;
  localparam md_op_t MD_MADD  = 3'd6;
  localparam md_op_t MD_MADDU = 3'd7;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_t;

endpackage

// File: rtl/md_calc.sv
// Combinational result generator: the {HI,LO} value a mult/div/madd will commit.
// Optional multiply-accumulate path is built only when MDU_MADD_EN is defined.
module md_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  md_op_t             i_op,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  output logic [2*WIDTH-1:0] o_result
);

  logic [2*WIDTH-1:0] w_sProd;
  logic [2*WIDTH-1:0] w_uProd;
  logic [WIDTH-1:0]   w_sQuot;
  logic [WIDTH-1:0]   w_sRem;
  logic [WIDTH-1:0]   w_uQuot;
  logic [WIDTH-1:0]   w_uRem;
  logic               w_divZero;
  logic               w_overflow;

  // Sign-extending to 2*WIDTH first makes the truncated product the exact signed result.
  assign w_sProd    = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_uProd    = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  assign w_sQuot    = $signed(i_a) / $signed(i_b);
  assign w_sRem     = $signed(i_a) % $signed(i_b);
  assign w_uQuot    = i_a / i_b;
  assign w_uRem     = i_a % i_b;
  assign w_divZero  = (i_b == '0);
  assign w_overflow = (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == {WIDTH{1'b1}});

`ifndef MDU_MADD_EN
  logic w_unused;
  assign w_unused = ^{i_hi, i_lo};
`endif

  always_comb begin
    o_result = '0;
    case (i_op)
      MD_MULT:  o_result = w_sProd;
      MD_MULTU: o_result = w_uProd;
      MD_DIV: begin
        if (w_divZero)       o_result = {i_a, {WIDTH{1'b1}}};
        else if (w_overflow) o_result = {{WIDTH{1'b0}}, i_a};
        else                 o_result = {w_sRem, w_sQuot};
      end
      MD_DIVU: begin
        if (w_divZero) o_result = {i_a, {WIDTH{1'b1}}};
        else           o_result = {w_uRem, w_uQuot};
      end
`ifdef MDU_MADD_EN
      MD_MADD:  o_result = {i_hi, i_lo} + w_sProd;
      MD_MADDU: o_result = {i_hi, i_lo} + w_uProd;
`endif
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// Define MDU_MADD_EN to enable madd/maddu (opcodes 6/7); otherwise they are ignored.
module md_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_t          r_state;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_pending;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] w_result;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .i_a      (A),
    .i_b      (B),
    .i_op     (MDOp),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result)
  );

  // The result is computed from the start-edge operands and parked until the counter expires.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= MD_IDLE;
      r_count   <= '0;
      r_pending <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (Start) begin
            case (MDOp)
              MD_MTHI: r_hi <= A;
              MD_MTLO: r_lo <= A;
`ifdef MDU_MADD_EN
              MD_MULT, MD_MULTU, MD_MADD, MD_MADDU: begin
`else
              MD_MULT, MD_MULTU: begin
`endif
                r_pending <= w_result;
                r_count   <= CW'(MULT_CYCLES);
                r_busy    <= 1'b1;
                r_state   <= MD_RUN;
              end
              MD_DIV, MD_DIVU: begin
                r_pending <= w_result;
                r_count   <= CW'(DIV_CYCLES);
                r_busy    <= 1'b1;
                r_state   <= MD_RUN;
              end
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            {r_hi, r_lo} <= r_pending;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= MD_IDLE;
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against an arithmetic model.
// Build with MDU_MADD_EN defined to expect the multiply-accumulate behaviour.
module tb_md_unit;
  import mdu_pkg::*;

  localparam int WIDTH       = 32;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MDOp  = 3'd0;
  logic [31:0] A     = '0;
  logic [31:0] B     = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  md_unit #(.WIDTH(WIDTH), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Architectural meaning of each op, in plain 64-bit arithmetic.
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
    longint na, nb, ma, mb, q, r;
    logic [63:0] sp, up;
    na = longint'(signed'(a));
    nb = longint'(signed'(b));
    sp = 64'(na * nb);
    up = {32'b0, a} * {32'b0, b};
    case (op)
      MD_MULT:  return sp;
      MD_MULTU: return up;
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        ma = (na < 0) ? -na : na;
        mb = (nb < 0) ? -nb : nb;
        q  = ma / mb;
        if ((na < 0) != (nb < 0)) q = -q;
        r  = na - q * nb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      MD_MTHI:  return {a, lo};
      MD_MTLO:  return {hi, a};
`ifdef MDU_MADD_EN
      MD_MADD:  return {hi, lo} + sp;
      MD_MADDU: return {hi, lo} + up;
`endif
      default:  return {hi, lo};
    endcase
  endfunction

  function automatic int latencyOf(input logic [2:0] op);
    case (op)
      MD_MULT, MD_MULTU: return MULT_CYCLES;
      MD_DIV, MD_DIVU:   return DIV_CYCLES;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: return MULT_CYCLES;
`endif
      default:           return 0;
    endcase
  endfunction

  // Entered and left just after a falling edge; leaves off in the Done cycle so the next call is back-to-back.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit interfere);
    logic [63:0] expected;
    int n;
    expected = refResult(op, a, b, modelHi, modelLo);
    n        = latencyOf(op);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    if (n == 0) begin
      {modelHi, modelLo} = expected;
      checkOutput("idle busy/done", {62'b0, Busy, Done}, 64'd0);
      checkOutput("immediate hilo", {HI, LO}, {modelHi, modelLo});
    end else begin
      for (int k = 0; k < n; k++) begin
        checkOutput("run busy/done", {62'b0, Busy, Done}, 64'd2);
        checkOutput("run hilo hold", {HI, LO}, {modelHi, modelLo});
        if (interfere && k == 2) begin
          Start = 1'b1; MDOp = MD_DIV; A = $urandom; B = $urandom;
        end
        @(negedge Clk);
        Start = 1'b0;
      end
      {modelHi, modelLo} = expected;
      checkOutput("done busy/done", {62'b0, Busy, Done}, 64'd1);
      checkOutput("done hilo", {HI, LO}, {modelHi, modelLo});
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    repeat (2) @(negedge Clk);
    checkOutput("reset hilo", {HI, LO}, 64'd0);
    checkOutput("reset busy/done", {62'b0, Busy, Done}, 64'd0);
    Reset = 1'b1;
    @(negedge Clk);

    applyStimulus(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    checkOutput("tp mult", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    applyStimulus(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
    checkOutput("tp multu", {HI, LO}, 64'h00000002_FFFFFFFA);
    applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    checkOutput("tp div", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus(MD_DIVU, 32'd7, 32'd0, 1'b0);
    checkOutput("tp divu by zero", {HI, LO}, 64'h00000007_FFFFFFFF);
    applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    checkOutput("tp div overflow", {HI, LO}, 64'h00000000_80000000);
    applyStimulus(MD_MTHI, 32'h1234, 32'd0, 1'b0);
    applyStimulus(MD_MTLO, 32'h5678, 32'd0, 1'b0);
    checkOutput("tp mthi/mtlo", {HI, LO}, 64'h00001234_00005678);

    applyStimulus(MD_MULT, 32'h00012345, 32'hFFFF0007, 1'b1);

    // Abort a divide mid-flight with the asynchronous reset.
    Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    checkOutput("abort hilo", {HI, LO}, 64'd0);
    checkOutput("abort busy/done", {62'b0, Busy, Done}, 64'd0);
    modelHi = '0; modelLo = '0;
    @(negedge Clk);
    Reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      checkOutput("post-abort quiet", {62'b0, Busy, Done}, 64'd0);
    end
    applyStimulus(MD_MULT, 32'd1000, 32'hFFFFFFFD, 1'b0);

    applyStimulus(MD_MTHI, 32'd0, 32'd0, 1'b0);
    applyStimulus(MD_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    applyStimulus(MD_MADDU, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    checkOutput("tp maddu", {HI, LO}, 64'h00000001_00000000);
`else
    checkOutput("tp maddu ignored", {HI, LO}, 64'h00000000_FFFFFFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) @(negedge Clk);
      applyStimulus(op, a, b, ($urandom_range(0, 4) == 0));
    end

    @(negedge Clk);
    checkOutput("final busy/done", {62'b0, Busy, Done}, 64'd0);
    checkOutput("final hilo", {HI, LO}, {modelHi, modelLo});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
